key_conditioner: RTL

Input-conditioning stage for the mini piano. It takes the seven raw, asynchronous, bouncing piano key switches and synchronizes and debounces each one. It produces clean held-key levels, one-cycle press/release events and an encoded note. Its outputs feed the controller's key input, which uses the levels and note, and learn-mode scoring, which uses the events.

---
 rtl/piano_pkg.sv | 28 ++
 rtl/key_conditioner_if.sv | 22 ++
 rtl/key_debounce_cell.sv | 53 +++++
 rtl/key_conditioner.sv | 60 ++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared mini-piano definitions: key count, note codes and the key-to-note encoder.
package piano_pkg;

  localparam int NUM_KEYS = 7;

  typedef logic [3:0]          note_t;
  typedef logic [NUM_KEYS-1:0] keys_t;

  localparam note_t NOTE_REST = 4'd0;
  localparam note_t NOTE_DO   = 4'd1;
  localparam note_t NOTE_RE   = 4'd2;
  localparam note_t NOTE_MI   = 4'd3;
  localparam note_t NOTE_FA   = 4'd4;
  localparam note_t NOTE_SOL  = 4'd5;
  localparam note_t NOTE_LA   = 4'd6;
  localparam note_t NOTE_TI   = 4'd7;

  // Lowest-index held key wins; scanning downward leaves the lowest set bit last.
  function automatic note_t encode_note(keys_t k);
    note_t n;
    n = NOTE_REST;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) n = note_t'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the raw switch side and the conditioned-key consumers.
interface key_conditioner_if;
  import piano_pkg::*;

  keys_t keys_raw;
  keys_t keys_stable;
  keys_t key_press;
  keys_t key_release;
  note_t note;
  logic  any_key;

  modport master (
    output keys_raw,
    input  keys_stable, key_press, key_release, note, any_key
  );

  modport slave (
    input  keys_raw,
    output keys_stable, key_press, key_release, note, any_key
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchronizer, saturating-threshold debounce counter and stable bit.
module key_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic st,
  output logic st_next,
  output logic rise,
  output logic fall
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreement with the stable level clears the count, so glitches never accumulate.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    st_d    = st_q;
    cnt_d   = '0;
    if (sync2_q != st_q) begin
      if (cnt_q == CNT_MAX) st_d  = sync2_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  assign st      = st_q;
  assign st_next = st_d;
  assign rise    = st_d & ~st_q;
  assign fall    = ~st_d & st_q;

endmodule

// File: rtl/key_conditioner.sv
// Per-key debounce array plus registered press/release events, note encoder and any_key.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int NUM_KEYS        = 7
) (
  input  logic             clk,
  input  logic             reset,
  key_conditioner_if.slave kif
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0] st, st_next, rise, fall;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  note_t               note_q, note_d;
  logic                any_q, any_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .key_raw (kif.keys_raw[i]),
      .st      (st[i]),
      .st_next (st_next[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // Everything keys off the next-state vector so it lands on the same edge as keys_stable.
  always_comb begin
    press_d   = rise;
    release_d = fall;
    note_d    = encode_note(st_next);
    any_d     = |st_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      note_q    <= NOTE_REST;
      any_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      note_q    <= note_d;
      any_q     <= any_d;
    end
  end

  assign kif.keys_stable = st;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.note        = note_q;
  assign kif.any_key     = any_q;

endmodule
